// File: rtl/nibble_addsub_sequencer_if.sv
// Control-side bus of the nibble add/sub sequencer.
// master: start/sub/op_a/op_b out; busy/done/result/carry_out/overflow in.
interface nibble_addsub_sequencer_if #(
   parameter int NIBBLES = 4
);
   localparam int WIDTH = 4 * NIBBLES;

   logic             start;
   logic             sub;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, sub, op_a, op_b,
      input  busy, done, result, carry_out, overflow
   );

   modport slave (
      input  start, sub, op_a, op_b,
      output busy, done, result, carry_out, overflow
   );
endinterface

// File: rtl/nibble_addsub_sequencer.sv
// Multi-cycle WIDTH-bit add/sub driving an external 4-bit adder, LSB nibble first.
// Ports: clk, rst_n (async low); bus (slave: start/sub/op_a/op_b in,
//   busy/done/result/carry_out/overflow out); add_a/add_b/add_c0 out,
//   add_s/add_c4 in. Macro ADDSUB_OVF_EN enables the overflow flag.
module nibble_addsub_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   nibble_addsub_sequencer_if.slave     bus,
   output logic [3:0]                   add_a,
   output logic [3:0]                   add_b,
   output logic                         add_c0,
   input  logic [3:0]                   add_s,
   input  logic                         add_c4
);
   localparam int WIDTH = 4 * NIBBLES;
   localparam int IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
   logic             w_run;
   logic [IW+1:0]    w_lsb;

   assign w_run = (r_state == S_RUN);
   assign w_lsb = {r_idx, 2'b00};

   // Adder inputs are only driven while running; quiet otherwise.
   assign add_a  = w_run ? r_a[w_lsb +: 4] : 4'h0;
   assign add_b  = w_run ? r_b[w_lsb +: 4] : 4'h0;
   assign add_c0 = w_run ? r_carry : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  // Subtract as A + ~B + 1: invert B now, seed carry with 1.
                  r_a     <= bus.op_a;
                  r_b     <= bus.sub ? ~bus.op_b : bus.op_b;
                  r_carry <= bus.sub;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_result[w_lsb +: 4] <= add_s;
               r_carry              <= add_c4;
               if (r_idx == LAST) begin
                  r_cout  <= add_c4;
                  r_idx   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ADDSUB_OVF_EN
   logic r_ovf;

   // Carry into the sign bit is recovered from the sign-bit sum;
   // overflow is that carry differing from the carry out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_run && (r_idx == LAST)) begin
         r_ovf <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ add_s[3] ^ add_c4;
      end
   end

   assign bus.overflow = r_ovf;
`else
   assign bus.overflow = 1'b0;
`endif

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.result    = r_result;
   assign bus.carry_out = r_cout;
endmodule

// File: tb/tb_nibble_addsub_sequencer.sv
// Directed bench for nibble_addsub_sequencer with a behavioural 4-bit adder.
// Expected values are hand-computed for NIBBLES=4.
module tb_nibble_addsub_sequencer;
   localparam int NIBBLES = 4;
   localparam int WIDTH   = 4 * NIBBLES;

   logic       clk;
   logic       rst_n;
   logic [3:0] add_a;
   logic [3:0] add_b;
   logic       add_c0;
   logic [3:0] add_s;
   logic       add_c4;

   int checks = 0;
   int errors = 0;

   nibble_addsub_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

   nibble_addsub_sequencer #(.NIBBLES(NIBBLES)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .add_a  (add_a),
      .add_b  (add_b),
      .add_c0 (add_c0),
      .add_s  (add_s),
      .add_c4 (add_c4)
   );

   always_comb begin
      {add_c4, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_c0};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef ADDSUB_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   // Launch one operation; returns edges from start cycle to done (0 = timeout).
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, output int n);
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = s;
      bus.op_a  = a;
      bus.op_b  = b;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.carry_out, bus.overflow} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000",
                  {bus.busy, bus.done, bus.carry_out, bus.overflow});
      end
      checks++;
      if (bus.result !== 16'h0000) begin
         errors++;
         $display("FAIL reset_result got %h want 0000", bus.result);
      end
      checks++;
      if ({add_a, add_b, add_c0} !== 9'h000) begin
         errors++;
         $display("FAIL reset_adder got %h want 000", {add_a, add_b, add_c0});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_op(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic s,
                          input logic [WIDTH-1:0] exp_r, input logic exp_c,
                          input logic exp_v);
      int n;
      run_op(a, b, s, n);
      checks++;
      if (n !== 5) begin
         errors++;
         $display("FAIL %s_latency got %0d want 5", name, n);
      end
      checks++;
      if (bus.result !== exp_r) begin
         errors++;
         $display("FAIL %s_result got %h want %h", name, bus.result, exp_r);
      end
      checks++;
      if ({bus.carry_out, bus.overflow, bus.busy} !== {exp_c, exp_v, 1'b0}) begin
         errors++;
         $display("FAIL %s_flags got c%b v%b busy%b want c%b v%b busy0", name,
                  bus.carry_out, bus.overflow, bus.busy, exp_c, exp_v);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.result !== exp_r) begin
         errors++;
         $display("FAIL %s_hold got done%b %h want done0 %h", name,
                  bus.done, bus.result, exp_r);
      end
   endtask

   task automatic test_start_ignored();
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = 1'b0;
      bus.op_a  = 16'h1234;
      bus.op_b  = 16'h0FFF;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL ign_busy_c%0d got busy%b done%b want busy1 done0",
                     c, bus.busy, bus.done);
         end
         bus.start = (c == 1);
         if (c == 1) begin
            bus.sub  = 1'b1;
            bus.op_a = 16'hAAAA;
            bus.op_b = 16'h5555;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      checks++;
      if (bus.done !== 1'b1 || bus.result !== 16'h2233) begin
         errors++;
         $display("FAIL ign_result got done%b %h want done1 2233",
                  bus.done, bus.result);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.result !== 16'h2233) begin
         errors++;
         $display("FAIL ign_noqueue got busy%b %h want busy0 2233",
                  bus.busy, bus.result);
      end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = 1'b0;
      bus.op_a  = 16'h1234;
      bus.op_b  = 16'h0FFF;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done} !== 2'b00 || bus.result !== 16'h0000 ||
          add_a !== 4'h0) begin
         errors++;
         $display("FAIL midrst got busy%b done%b %h a%h want 0 0 0000 0",
                  bus.busy, bus.done, bus.result, add_a);
      end
      repeat (6) begin
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_done got %b want 0", bus.done);
         end
      end
      rst_n = 1'b1;
      test_op("restart", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = 1'b0;
      bus.op_a  = 16'h00F0;
      bus.op_b  = 16'h0010;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            n = i;
            break;
         end
      end
      checks++;
      if (n !== 5 || bus.result !== 16'h0100) begin
         errors++;
         $display("FAIL b2b_first got n%0d %h want n5 0100", n, bus.result);
      end
      bus.op_a = 16'h0001;
      bus.op_b = 16'h0002;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            n = i;
            break;
         end
      end
      bus.start = 1'b0;
      checks++;
      if (n !== 6 || bus.result !== 16'h0003) begin
         errors++;
         $display("FAIL b2b_second got n%0d %h want n6 0003", n, bus.result);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_op("add1", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      test_op("addwrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      test_op("sub1", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      test_op("addovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_ON);
      test_op("subovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, OVF_ON);
      test_op("subeq", 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0);
      test_start_ignored();
      test_reset_mid_run();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end
endmodule
